// File: rtl/bist_pkg.sv
// March C- BIST shared definitions: FSM state codes, element op table, backgrounds.
package bist_pkg;

    localparam int unsigned STATE_W      = 4;
    localparam int unsigned OPS_PER_CELL = 10;
    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned OPS_TOTAL    = OPS_PER_CELL * (2 ** DEF_ADDR_W);

    localparam logic [STATE_W-1:0] S_IDLE  = 4'd0;
    localparam logic [STATE_W-1:0] S_M0    = 4'd1;
    localparam logic [STATE_W-1:0] S_M1    = 4'd2;
    localparam logic [STATE_W-1:0] S_M2    = 4'd3;
    localparam logic [STATE_W-1:0] S_M3    = 4'd4;
    localparam logic [STATE_W-1:0] S_M4    = 4'd5;
    localparam logic [STATE_W-1:0] S_M5    = 4'd6;
    localparam logic [STATE_W-1:0] S_DRAIN = 4'd7;
    localparam logic [STATE_W-1:0] S_DONE  = 4'd8;

    localparam logic BG0 = 1'b0;
    localparam logic BG1 = 1'b1;

    // Per-element descriptor; bit 0 of we/bg is the first op on a cell, bit 1 the second.
    typedef struct packed {
        logic       down;
        logic       two_ops;
        logic [1:0] we;
        logic [1:0] bg;
    } elem_t;

    function automatic elem_t elem_info(input logic [STATE_W-1:0] st);
        elem_t e;
        e = '0;
        case (st)
            S_M0:    e = '{down: 1'b0, two_ops: 1'b0, we: 2'b01, bg: {BG0, BG0}};
            S_M1:    e = '{down: 1'b0, two_ops: 1'b1, we: 2'b10, bg: {BG1, BG0}};
            S_M2:    e = '{down: 1'b0, two_ops: 1'b1, we: 2'b10, bg: {BG0, BG1}};
            S_M3:    e = '{down: 1'b1, two_ops: 1'b1, we: 2'b10, bg: {BG1, BG0}};
            S_M4:    e = '{down: 1'b1, two_ops: 1'b1, we: 2'b10, bg: {BG0, BG1}};
            S_M5:    e = '{down: 1'b1, two_ops: 1'b0, we: 2'b00, bg: {BG0, BG0}};
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic is_march(input logic [STATE_W-1:0] st);
        return (st >= S_M0) && (st <= S_M5);
    endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Loadable up/down address counter; terminal count is max when counting up, 0 when counting down.
module march_addr_gen #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              tc_c
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              down_q, down_d;

    always_comb begin
        addr_d = addr_q;
        down_d = down_q;
        if (load) begin
            down_d = load_down;
            addr_d = load_down ? '1 : '0;
        end else if (step) begin
            addr_d = down_q ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            down_q <= down_d;
        end
    end

    assign addr = addr_q;
    assign tc_c = down_q ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST controller: sequences SRAM ops, compares read data, reports Done/GoNoGo.
// Define BIST_DIAG_EN to enable first-fail address and miscompare count capture.
module march_bist_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    output logic [ADDR_W-1:0] Sram_Addr,
    output logic              Sram_WE,
    output logic [DATA_W-1:0] Sram_Din,
    input  logic [DATA_W-1:0] Sram_Dout,
    output logic              Busy,
    output logic              Done,
    output logic              GoNoGo,
    output logic [ADDR_W-1:0] Fail_Addr,
    output logic [7:0]        Fail_Cnt
);

    localparam int unsigned STG_W  = 1 + DATA_W;
    localparam int unsigned PIPE_W = READ_LAT * STG_W;

    logic [STATE_W-1:0] state_q, state_d;
    logic               idx_q, idx_d;
    logic [1:0]         drain_q, drain_d;
    logic               we_q, we_d;
    logic               rd_q, rd_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               go_q, go_d;
    logic [PIPE_W-1:0]  pipe_q, pipe_d;

    logic               ag_load, ag_down, ag_step, ag_tc;
    logic               start_acc;
    logic [STG_W-1:0]   cmp_stg;
    logic               miscmp_c;

    march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (Clock),
        .rst       (Reset),
        .load      (ag_load),
        .load_down (ag_down),
        .step      (ag_step),
        .addr      (Sram_Addr),
        .tc_c      (ag_tc)
    );

    // Oldest pipeline stage lines up with Sram_Dout for the read it tracks.
    assign cmp_stg  = pipe_q[PIPE_W-1 -: STG_W];
    assign miscmp_c = cmp_stg[STG_W-1] && (Sram_Dout != cmp_stg[DATA_W-1:0]);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        we_d      = 1'b0;
        rd_d      = 1'b0;
        din_d     = '0;
        busy_d    = busy_q;
        done_d    = done_q;
        go_d      = go_q;
        ag_load   = 1'b0;
        ag_step   = 1'b0;
        start_acc = 1'b0;
        pipe_d    = PIPE_W'({pipe_q, rd_q, din_q});

        if (miscmp_c) begin
            go_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    start_acc = 1'b1;
                    state_d   = S_M0;
                    idx_d     = 1'b0;
                    ag_load   = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    go_d      = 1'b1;
                end
            end
            S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
                if (!idx_q && elem_info(state_q).two_ops) begin
                    idx_d = 1'b1;
                end else if (!ag_tc) begin
                    idx_d   = 1'b0;
                    ag_step = 1'b1;
                end else begin
                    idx_d = 1'b0;
                    if (state_q == S_M5) begin
                        state_d = S_DRAIN;
                        drain_d = 2'(READ_LAT - 1);
                    end else begin
                        state_d = state_q + 4'd1;
                        ag_load = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Present the op selected by the next state/op index.
        ag_down = elem_info(state_d).down;
        if (is_march(state_d)) begin
            we_d  = elem_info(state_d).we[idx_d];
            rd_d  = !we_d;
            din_d = {DATA_W{elem_info(state_d).bg[idx_d]}};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= 1'b0;
            drain_q <= 2'd0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            go_q    <= 1'b0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            go_q    <= go_d;
            pipe_q  <= pipe_d;
        end
    end

    assign Sram_WE  = we_q;
    assign Sram_Din = din_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign GoNoGo   = go_q;

`ifdef BIST_DIAG_EN
    localparam int unsigned APIPE_W = READ_LAT * ADDR_W;

    logic [APIPE_W-1:0] apipe_q, apipe_d;
    logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;
    logic [7:0]         fail_cnt_q, fail_cnt_d;

    // Address pipeline tracks the same ops as the compare pipeline.
    always_comb begin
        apipe_d     = APIPE_W'({apipe_q, Sram_Addr});
        fail_addr_d = fail_addr_q;
        fail_cnt_d  = fail_cnt_q;
        if (start_acc) begin
            fail_addr_d = '0;
            fail_cnt_d  = 8'd0;
        end else if (miscmp_c) begin
            if (fail_cnt_q == 8'd0) begin
                fail_addr_d = apipe_q[APIPE_W-1 -: ADDR_W];
            end
            if (fail_cnt_q != 8'hFF) begin
                fail_cnt_d = fail_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            apipe_q     <= '0;
            fail_addr_q <= '0;
            fail_cnt_q  <= 8'd0;
        end else begin
            apipe_q     <= apipe_d;
            fail_addr_q <= fail_addr_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign Fail_Addr = fail_addr_q;
    assign Fail_Cnt  = fail_cnt_q;
`else
    assign Fail_Addr = '0;
    assign Fail_Cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Self-checking bench for march_bist_ctrl against a behavioural SRAM with injectable stuck-at faults.
module tb_march_bist_ctrl;

    localparam int unsigned RL    = 1;
    localparam int unsigned DEPTH = 256;
    localparam int          NOPS  = 2560;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] Sram_Addr;
    logic       Sram_WE;
    logic [3:0] Sram_Din;
    logic [3:0] Sram_Dout;
    logic       Busy, Done, GoNoGo;
    logic [7:0] Fail_Addr;
    logic [7:0] Fail_Cnt;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    march_bist_ctrl #(.ADDR_W(8), .DATA_W(4), .READ_LAT(RL)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Sram_Addr (Sram_Addr),
        .Sram_WE   (Sram_WE),
        .Sram_Din  (Sram_Din),
        .Sram_Dout (Sram_Dout),
        .Busy      (Busy),
        .Done      (Done),
        .GoNoGo    (GoNoGo),
        .Fail_Addr (Fail_Addr),
        .Fail_Cnt  (Fail_Cnt)
    );

    // Synchronous SRAM with RL-cycle read latency and a stuck-at fault on read.
    logic [3:0] mem   [DEPTH];
    logic [3:0] dpipe [RL];
    logic       fault_en, fault_all, fault_sa1;
    logic [7:0] fault_addr;

    function automatic logic [3:0] rd_val(input logic [7:0] a);
        logic [3:0] m;
        m = mem[a];
        if (fault_en && (fault_all || a == fault_addr))
            m = fault_sa1 ? (m | 4'b0001) : (m & 4'b0111);
        return m;
    endfunction

    always @(posedge Clock) begin
        if (Sram_WE) mem[Sram_Addr] <= Sram_Din;
        dpipe[0] <= rd_val(Sram_Addr);
        for (int i = 1; i < int'(RL); i++) dpipe[i] <= dpipe[i-1];
    end
    assign Sram_Dout = dpipe[RL-1];

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [3:0] din;
    } op_t;

    typedef struct {
        logic       go;
        logic [7:0] fa;
        logic [7:0] fc;
    } res_t;

    typedef struct {
        string      name;
        logic       f_en;
        logic       f_all;
        logic       f_sa1;
        logic [7:0] f_addr;
        int         glitch_op;
        logic       go;
        logic [7:0] fa;
        logic [7:0] fc;
    } vec_t;

    op_t  exp_ops [$];
    res_t exp_res [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // March C- written as op strings per element; elements 3..5 walk addresses downward.
    task automatic push_march_trace();
        string el [6];
        el = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                for (int j = 0; j < el[e].len() / 2; j++) begin
                    op_t o;
                    o.we   = (el[e][2*j] == "w");
                    o.addr = (e >= 3) ? 8'(255 - k) : 8'(k);
                    o.din  = (el[e][2*j+1] == "1") ? 4'hF : 4'h0;
                    exp_ops.push_back(o);
                end
            end
        end
    endtask

    function automatic vec_t mk_vec(input string n, input logic en, input logic all, input logic sa1,
                                    input logic [7:0] fa_in, input int g, input logic go,
                                    input logic [7:0] fa, input logic [7:0] fc);
        vec_t v;
        v.name = n; v.f_en = en; v.f_all = all; v.f_sa1 = sa1; v.f_addr = fa_in;
        v.glitch_op = g; v.go = go; v.fa = fa; v.fc = fc;
        return v;
    endfunction

    task automatic run_march(input vec_t v);
        int   bad_ops = 0;
        int   wr_cnt  = 0;
        int   edge_n;
        string first_bad = "";
        res_t r;
        logic [7:0] efa, efc;

        fault_en = v.f_en; fault_all = v.f_all; fault_sa1 = v.f_sa1; fault_addr = v.f_addr;
        @(negedge Clock);
        Start = 1'b1;
        push_march_trace();
        exp_res.push_back('{go: v.go, fa: v.fa, fc: v.fc});
        @(negedge Clock);
        Start = 1'b0;
        check({v.name, ".busy_after_start"}, 32'(Busy), 32'd1);
        check({v.name, ".done_cleared"}, 32'(Done), 32'd0);
        check({v.name, ".go_set"}, 32'(GoNoGo), 32'd1);

        for (int k = 1; k <= NOPS; k++) begin
            op_t e;
            e = exp_ops.pop_front();
            if (Sram_WE !== e.we || Sram_Addr !== e.addr || (e.we && Sram_Din !== e.din) || Busy !== 1'b1) begin
                if (bad_ops == 0)
                    first_bad = $sformatf("op%0d we=%0b addr=%0h din=%0h busy=%0b want we=%0b addr=%0h din=%0h",
                                          k, Sram_WE, Sram_Addr, Sram_Din, Busy, e.we, e.addr, e.din);
                bad_ops++;
            end
            if (Sram_WE) wr_cnt++;
            if (k == v.glitch_op) Start = 1'b1;
            @(negedge Clock);
            Start = 1'b0;
        end

        check({v.name, ".busy_in_drain"}, 32'({Busy, Done}), 32'b10);
        edge_n = NOPS;
        while (!Done && edge_n < NOPS + 20) begin
            if (Sram_WE) wr_cnt++;
            @(negedge Clock);
            edge_n++;
        end
        r = exp_res.pop_front();
`ifdef BIST_DIAG_EN
        efa = r.fa; efc = r.fc;
`else
        efa = 8'h00; efc = 8'h00;
`endif
        if (bad_ops != 0) $display("FAIL %s.op_trace: %0d bad ops, first %s", v.name, bad_ops, first_bad);
        check({v.name, ".op_trace_bad"}, 32'(bad_ops), 32'd0);
        check({v.name, ".done_edge"}, 32'(edge_n), 32'(NOPS + int'(RL)));
        check({v.name, ".write_count"}, 32'(wr_cnt), 32'd1280);
        check({v.name, ".busy_at_done"}, 32'(Busy), 32'd0);
        check({v.name, ".gonogo"}, 32'(GoNoGo), 32'(r.go));
        check({v.name, ".fail_addr"}, 32'(Fail_Addr), 32'(efa));
        check({v.name, ".fail_cnt"}, 32'(Fail_Cnt), 32'(efc));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        vecs[0] = mk_vec("clean",        1'b0, 1'b0, 1'b0, 8'h00, 0,   1'b1, 8'h00, 8'd0);
        vecs[1] = mk_vec("sa1_3c",       1'b1, 1'b0, 1'b1, 8'h3C, 0,   1'b0, 8'h3C, 8'd3);
        vecs[2] = mk_vec("start_busy",   1'b0, 1'b0, 1'b0, 8'h00, 500, 1'b1, 8'h00, 8'd0);
        vecs[3] = mk_vec("sa1_ff",       1'b1, 1'b0, 1'b1, 8'hFF, 0,   1'b0, 8'hFF, 8'd3);
        vecs[4] = mk_vec("sa0_b3_00",    1'b1, 1'b0, 1'b0, 8'h00, 0,   1'b0, 8'h00, 8'd2);
        vecs[5] = mk_vec("sa1_all",      1'b1, 1'b1, 1'b1, 8'h00, 0,   1'b0, 8'h00, 8'd255);
        vecs[6] = mk_vec("clean_rerun",  1'b0, 1'b0, 1'b0, 8'h00, 0,   1'b1, 8'h00, 8'd0);

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 4'h0;
        for (int i = 0; i < int'(RL); i++) dpipe[i] = 4'h0;
        fault_en = 1'b0; fault_all = 1'b0; fault_sa1 = 1'b0; fault_addr = 8'h00;
        Reset = 1'b1;
        Start = 1'b0;
        repeat (3) @(negedge Clock);

        check("rst.addr",   32'(Sram_Addr), 32'd0);
        check("rst.we",     32'(Sram_WE),   32'd0);
        check("rst.din",    32'(Sram_Din),  32'd0);
        check("rst.busy",   32'(Busy),      32'd0);
        check("rst.done",   32'(Done),      32'd0);
        check("rst.gonogo", 32'(GoNoGo),    32'd0);
        check("rst.fa",     32'(Fail_Addr), 32'd0);
        check("rst.fc",     32'(Fail_Cnt),  32'd0);

        // Start together with Reset must be dropped.
        Start = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        @(negedge Clock);
        check("start_under_reset.busy", 32'(Busy), 32'd0);

        for (int i = 0; i < 7; i++) run_march(vecs[i]);

        // Reset in the middle of M2 (op 1000 is w0 at 0x73).
        fault_en = 1'b0;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (999) @(negedge Clock);
        check("midrst.op1000", 32'({Sram_WE, Sram_Addr}), 32'({1'b1, 8'h73}));
        #2 Reset = 1'b1;
        #1;
        check("midrst.we_async", 32'(Sram_WE), 32'd0);
        check("midrst.busy", 32'(Busy), 32'd0);
        check("midrst.done", 32'(Done), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (RL + 3) @(negedge Clock);
        check("midrst.no_done_pulse", 32'({Busy, Done}), 32'd0);

        run_march(mk_vec("after_reset", 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 8'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
